// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
//   Bit-serial operand sequencer that wraps an external 1-bit full adder.
//   It loads two N-bit operands and a carry-in, then for N cycles presents
//   one bit of each operand (LSB first) and a registered carry to the adder.
//   Each returned sum bit is shifted into the result MSB-first, so after N
//   edges the result is LSB-aligned.
//
// Parameters
//   N            operand/result width, N >= 1
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, accepted on an edge where ready=1
//   a_in/b_in    operands, sampled on accept
//   ci_in        carry-in, sampled on accept
//   ready        high in IDLE only
//   fa_a/fa_b    operand bits to the adder (0 outside SHIFT)
//   fa_ci        registered carry to the adder (0 outside SHIFT)
//   fa_sum/fa_co sum and carry returned by the adder
//   result       accumulated sum, LSB-aligned
//   co_out       final carry-out
//   result_valid result/co_out valid (DONE)
//   result_ready consumer accepts the result
module serial_add_sequencer #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         ci_in,
  output logic         ready,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_ci,
  input  logic         fa_sum,
  input  logic         fa_co,
  output logic [N-1:0] result,
  output logic         co_out,
  output logic         result_valid,
  input  logic         result_ready
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e          state_q;
  logic [N-1:0]    a_sr_q;
  logic [N-1:0]    b_sr_q;
  logic [N-1:0]    result_q;
  logic            carry_q;
  logic            co_out_q;
  logic [CntW-1:0] cnt_q;

  // Incoming sum bit placed at the MSB; written this way so N=1 needs no
  // zero-width slice.
  logic [N-1:0]    sum_msb;

  always_comb begin
    sum_msb        = '0;
    sum_msb[N-1]   = fa_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      co_out_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sr_q   <= a_in;
            b_sr_q   <= b_in;
            carry_q  <= ci_in;
            cnt_q    <= '0;
            result_q <= '0;
            state_q  <= StShift;
          end
        end
        StShift: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          result_q <= (result_q >> 1) | sum_msb;
          carry_q  <= fa_co;
          if (cnt_q == CntLast) begin
            co_out_q <= fa_co;
            cnt_q    <= '0;
            state_q  <= StDone;
          end else begin
            cnt_q    <= cnt_q + CntOne;
          end
        end
        StDone: begin
          // start is ignored here, even when it coincides with result_ready.
          if (result_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Adder drive depends only on registers, so there is no path from
  // fa_sum/fa_co back to fa_*.
  always_comb begin
    fa_a  = 1'b0;
    fa_b  = 1'b0;
    fa_ci = 1'b0;
    if (state_q == StShift) begin
      fa_a  = a_sr_q[0];
      fa_b  = b_sr_q[0];
      fa_ci = carry_q;
    end
  end

  assign ready        = (state_q == StIdle);
  assign result_valid = (state_q == StDone);
  assign result       = result_q;
  assign co_out       = co_out_q;

endmodule
